// File: rtl/rom_burst_writer.sv
// rom_burst_writer: writable 256x8 table loaded by burst commands over a
// valid/ready byte stream, with the same gated combinational read port as
// the lookup ROM it complements.
module rom_burst_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              ce,
  input  logic              read_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr;
  logic [ADDR_W:0]    r_remaining;
  logic [ADDR_W:0]    r_wr_count;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic               w_cmd_fire;
  logic               w_wr_fire;
  logic               w_last_byte;

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_wr_fire   = wr_valid && wr_ready;
  assign w_last_byte = (r_remaining == CNT_ONE);
  assign wr_count    = r_wr_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a burst ends on the byte accepted with one remaining
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmd_fire) w_state_nxt = S_WRITE;
      S_WRITE: if (w_wr_fire && w_last_byte) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded purely from state
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE:  cmd_ready = 1'b1;
      S_WRITE: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Burst bookkeeping: pointer, bytes remaining (9-bit so 256 fits), count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_wr_count  <= '0;
    end else if (w_cmd_fire) begin
      r_ptr       <= cmd_addr;
      r_remaining <= {1'b0, cmd_len} + CNT_ONE;
      r_wr_count  <= '0;
    end else if (w_wr_fire) begin
      r_ptr       <= r_ptr + PTR_ONE;
      r_remaining <= r_remaining - CNT_ONE;
      r_wr_count  <= r_wr_count + CNT_ONE;
    end
  end

  // Storage array: deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_ptr] <= wr_data;
    end
  end

  // Gated combinational read, zero when not enabled
  always_comb begin
    rd_data = '0;
    if (ce && read_en) begin
      rd_data = r_mem[rd_addr];
    end
  end

endmodule
